vp_host_loader: RTL and testbench

Host-side sequencer that drives the vertex processor's external programming and data ports. It accepts single-word commands over a valid/ready interface, then writes instruction memory or vertex info memory, runs the processor for a given number of cycles, or reads back a 128-bit vertex word. It sits between the system/host bus and one vertex processor instance, and is the only agent that drives that instance's `enable`, `reset`, `we_ins_m`, `addr_ins_m`, `din_ins_m`, `info_in`, `addr_inf` and `we_inf` inputs.

---
 rtl/vp_host_loader_pkg.sv | 28 ++
 rtl/vp_run_counter.sv | 34 +++
 rtl/vp_host_loader.sv | 143 ++++++++++++++
 tb/tb_vp_host_loader.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/vp_host_loader_pkg.sv
// Shared constants for the vertex processor host loader: opcodes, FSM
// encoding and the default widths matching the vertex processor instance.
package vp_host_loader_pkg;

  localparam int DEF_PC_INS_ADDR_W = 8;
  localparam int DEF_INS_DATA_W    = 15;
  localparam int DEF_INFO_W        = 128;
  localparam int DEF_INFO_ADDR_W   = 8;
  localparam int DEF_RUN_W         = 16;
  localparam int CMD_ADDR_W        = 8;

  localparam logic [1:0] OP_LOAD_INS  = 2'd0;
  localparam logic [1:0] OP_LOAD_INFO = 2'd1;
  localparam logic [1:0] OP_RUN       = 2'd2;
  localparam logic [1:0] OP_READ      = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_INS  = 3'd1,
    ST_WR_INF  = 3'd2,
    ST_PC_CLR  = 3'd3,
    ST_RUN     = 3'd4,
    ST_RD_ADDR = 3'd5,
    ST_RD_CAP  = 3'd6,
    ST_RSP     = 3'd7
  } state_t;

endpackage

// File: rtl/vp_run_counter.sv
// Loadable run-length down-counter; last flags a count of exactly one so the
// sequencer leaves RUN without needing an extra cycle or a wrap.
module vp_run_counter #(
  parameter int RUN_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [RUN_W-1:0] load_val,
  input  logic             dec,
  output logic             last
);

  localparam logic [RUN_W-1:0] ONE  = {{(RUN_W-1){1'b0}}, 1'b1};
  localparam logic [RUN_W-1:0] ZERO = {RUN_W{1'b0}};

  logic [RUN_W-1:0] count_r;

  // Load has priority over decrement; decrement saturates at zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_r <= ZERO;
    end else if (load) begin
      count_r <= load_val;
    end else if (dec && (count_r != ZERO)) begin
      count_r <= count_r - ONE;
    end else begin
      count_r <= count_r;
    end
  end

  assign last = (count_r == ONE);

endmodule

// File: rtl/vp_host_loader.sv
// Host-side sequencer: turns single-word commands into instruction/info
// memory writes, timed processor runs and registered info readbacks.
module vp_host_loader
  import vp_host_loader_pkg::*;
#(
  parameter int PC_INS_ADDR_W = DEF_PC_INS_ADDR_W,
  parameter int INS_DATA_W    = DEF_INS_DATA_W,
  parameter int INFO_W        = DEF_INFO_W,
  parameter int INFO_ADDR_W   = DEF_INFO_ADDR_W,
  parameter int RUN_W         = DEF_RUN_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [1:0]               cmd_op,
  input  logic [CMD_ADDR_W-1:0]    cmd_addr,
  input  logic [INFO_W-1:0]        cmd_data,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [INFO_W-1:0]        rsp_data,
  output logic                     busy,
  output logic                     done,
  output logic                     vp_enable,
  output logic                     vp_reset,
  output logic                     vp_we_ins_m,
  output logic [PC_INS_ADDR_W-1:0] vp_addr_ins_m,
  output logic [INS_DATA_W-1:0]    vp_din_ins_m,
  output logic                     vp_we_inf,
  output logic [INFO_ADDR_W-1:0]   vp_addr_inf,
  output logic [INFO_W-1:0]        vp_info_in,
  input  logic [INFO_W-1:0]        vp_vert_out
);

  state_t                   state_r, state_nx_s;
  logic [PC_INS_ADDR_W-1:0] ins_addr_r;
  logic [INS_DATA_W-1:0]    ins_data_r;
  logic [INFO_ADDR_W-1:0]   info_addr_r;
  logic [INFO_W-1:0]        info_data_r;
  logic [INFO_W-1:0]        rsp_data_r;
  logic                     done_r;
  logic                     accept_s, run_zero_s, cnt_load_s, cnt_last_s;
  logic [RUN_W-1:0]         run_n_s;

  assign cmd_ready  = (state_r == ST_IDLE) & ~reset;
  assign accept_s   = cmd_valid & cmd_ready;
  assign run_n_s    = cmd_data[RUN_W-1:0];
  assign run_zero_s = (run_n_s == {RUN_W{1'b0}});
  assign cnt_load_s = accept_s && (cmd_op == OP_RUN) && !run_zero_s;

  vp_run_counter #(.RUN_W(RUN_W)) u_run_counter (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load_s),
    .load_val (run_n_s),
    .dec      (state_r == ST_RUN),
    .last     (cnt_last_s)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state decode.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          case (cmd_op)
            OP_LOAD_INS:  state_nx_s = ST_WR_INS;
            OP_LOAD_INFO: state_nx_s = ST_WR_INF;
            OP_RUN:       state_nx_s = run_zero_s ? ST_IDLE : ST_PC_CLR;
            OP_READ:      state_nx_s = ST_RD_ADDR;
            default:      state_nx_s = ST_IDLE;
          endcase
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_WR_INS:  state_nx_s = ST_IDLE;
      ST_WR_INF:  state_nx_s = ST_IDLE;
      ST_PC_CLR:  state_nx_s = ST_RUN;
      ST_RUN:     state_nx_s = cnt_last_s ? ST_IDLE : ST_RUN;
      ST_RD_ADDR: state_nx_s = ST_RD_CAP;
      ST_RD_CAP:  state_nx_s = ST_RSP;
      ST_RSP:     state_nx_s = rsp_ready ? ST_IDLE : ST_RSP;
      default:    state_nx_s = ST_IDLE;
    endcase
  end

  // Command operand capture, readback capture and the done pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      ins_addr_r  <= {PC_INS_ADDR_W{1'b0}};
      ins_data_r  <= {INS_DATA_W{1'b0}};
      info_addr_r <= {INFO_ADDR_W{1'b0}};
      info_data_r <= {INFO_W{1'b0}};
      rsp_data_r  <= {INFO_W{1'b0}};
      done_r      <= 1'b0;
    end else begin
      if (accept_s) begin
        case (cmd_op)
          OP_LOAD_INS: begin
            ins_addr_r <= cmd_addr[PC_INS_ADDR_W-1:0];
            ins_data_r <= cmd_data[INS_DATA_W-1:0];
          end
          OP_LOAD_INFO: begin
            info_addr_r <= cmd_addr[INFO_ADDR_W-1:0];
            info_data_r <= cmd_data;
          end
          OP_READ: info_addr_r <= cmd_addr[INFO_ADDR_W-1:0];
          default: info_addr_r <= info_addr_r;
        endcase
      end
      // The memory read is registered, so data for the RD_ADDR address is here now.
      if (state_r == ST_RD_CAP) begin
        rsp_data_r <= vp_vert_out;
      end
      done_r <= (accept_s && (cmd_op == OP_RUN) && run_zero_s) ||
                ((state_r == ST_RUN) && cnt_last_s);
    end
  end

  assign busy          = (state_r != ST_IDLE);
  assign done          = done_r;
  assign rsp_valid     = (state_r == ST_RSP);
  assign rsp_data      = rsp_data_r;
  assign vp_enable     = (state_r == ST_RUN);
  assign vp_reset      = reset | (state_r == ST_PC_CLR);
  assign vp_we_ins_m   = (state_r == ST_WR_INS);
  assign vp_addr_ins_m = ins_addr_r;
  assign vp_din_ins_m  = ins_data_r;
  assign vp_we_inf     = (state_r == ST_WR_INF);
  assign vp_addr_inf   = info_addr_r;
  assign vp_info_in    = info_data_r;

endmodule

// File: tb/tb_vp_host_loader.sv
// Scoreboard bench for vp_host_loader: the driver queues expected effects of
// each command, a negedge monitor pops and checks them against DUT activity.
module tb_vp_host_loader;

  logic         clk = 1'b0;
  logic         reset, cmd_valid, cmd_ready, rsp_valid, rsp_ready, busy, done;
  logic [1:0]   cmd_op;
  logic [7:0]   cmd_addr;
  logic [127:0] cmd_data, rsp_data, vp_info_in, vp_vert_out;
  logic         vp_enable, vp_reset, vp_we_ins_m, vp_we_inf;
  logic [7:0]   vp_addr_ins_m, vp_addr_inf;
  logic [14:0]  vp_din_ins_m;

  always #5 clk = ~clk;

  vp_host_loader dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .busy(busy), .done(done), .vp_enable(vp_enable), .vp_reset(vp_reset),
    .vp_we_ins_m(vp_we_ins_m), .vp_addr_ins_m(vp_addr_ins_m),
    .vp_din_ins_m(vp_din_ins_m), .vp_we_inf(vp_we_inf),
    .vp_addr_inf(vp_addr_inf), .vp_info_in(vp_info_in),
    .vp_vert_out(vp_vert_out)
  );

  localparam int K_INS = 0, K_INF = 1, K_DONE = 2, K_RSP = 3;
  typedef struct {
    int           kind;
    logic [7:0]   addr;
    logic [127:0] data;
    int           n;
    int           acc;
  } exp_t;

  exp_t         sb[$];
  logic [127:0] ref_info [256];
  logic [127:0] mem [256];
  int           cyc = 0;
  int           tests = 0, fails = 0;
  int           en_cnt = 0, pc_cnt = 0, en_first = 0, pc_cyc = 0, first_v = -1;
  bit           prev_hold = 1'b0;
  bit           rand_rdy = 1'b0;
  logic [127:0] prev_data;

  always @(posedge clk) cyc <= cyc + 1;

  // Info memory with a one-cycle registered read, as the processor has.
  always @(posedge clk) begin
    if (vp_we_inf) mem[vp_addr_inf] <= vp_info_in;
    vp_vert_out <= mem[vp_addr_inf];
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic send(input logic [1:0] op, input logic [7:0] a, input logic [127:0] d,
                      input bit hold, output int acc);
    exp_t e;
    int   w = 0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = a; cmd_data = d;
    while (!cmd_ready && w < 500) begin
      @(negedge clk);
      w++;
    end
    acc = cyc;
    if (!cmd_ready) begin
      chk("accept_timeout", 128'd0, 128'd1);
      cmd_valid = 1'b0;
    end else begin
      e.addr = a; e.acc = cyc; e.n = 0; e.data = '0;
      case (op)
        2'd0: begin e.kind = K_INS; e.data = {113'd0, d[14:0]}; end
        2'd1: begin e.kind = K_INF; e.data = d; ref_info[a] = d; end
        2'd2: begin e.kind = K_DONE; e.n = int'(d[15:0]); end
        default: begin e.kind = K_RSP; e.data = ref_info[a]; end
      endcase
      sb.push_back(e);
      @(posedge clk);
      #1;
      if (!hold) cmd_valid = 1'b0;
    end
  endtask

  task automatic wait_drain();
    int w = 0;
    while (sb.size() != 0 && w < 2000) begin
      @(negedge clk);
      w++;
    end
    if (sb.size() != 0) chk("drain_timeout", sb.size(), 0);
  endtask

  // Monitor: pops one expectation per observed strobe, done pulse or handshake.
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      en_cnt = 0; pc_cnt = 0; first_v = -1; prev_hold = 1'b0;
    end else begin
      if (vp_reset) begin pc_cnt++; pc_cyc = cyc; end
      if (vp_enable) begin
        if (en_cnt == 0) en_first = cyc;
        en_cnt++;
      end
      if (vp_we_ins_m || vp_we_inf || done || (rsp_valid && rsp_ready)) begin
        if (sb.size() == 0) begin
          chk("unexpected_event", 128'd1, 128'd0);
        end else begin
          e = sb.pop_front();
          if (vp_we_ins_m) begin
            chk("ins_kind", e.kind, K_INS);
            chk("ins_addr", vp_addr_ins_m, e.addr);
            chk("ins_data", vp_din_ins_m, e.data);
            chk("ins_latency", cyc, e.acc + 1);
            chk("ins_we_excl", vp_we_inf, 1'b0);
          end else if (vp_we_inf) begin
            chk("inf_kind", e.kind, K_INF);
            chk("inf_addr", vp_addr_inf, e.addr);
            chk("inf_data", vp_info_in, e.data);
            chk("inf_latency", cyc, e.acc + 1);
          end else if (done) begin
            chk("done_kind", e.kind, K_DONE);
            chk("run_enable_cycles", en_cnt, e.n);
            if (e.n == 0) begin
              chk("done_latency_n0", cyc, e.acc + 1);
              chk("run_n0_no_pc_clr", pc_cnt, 0);
            end else begin
              chk("done_latency", cyc, e.acc + 2 + e.n);
              chk("run_pc_clr_count", pc_cnt, 1);
              chk("run_pc_clr_cycle", pc_cyc, e.acc + 1);
              chk("run_enable_first", en_first, e.acc + 2);
            end
            en_cnt = 0; pc_cnt = 0;
          end else begin
            if (first_v < 0) first_v = cyc;
            chk("rsp_kind", e.kind, K_RSP);
            chk("rsp_data", rsp_data, e.data);
            chk("rsp_latency", first_v, e.acc + 3);
          end
        end
      end
      if (rsp_valid && first_v < 0) first_v = cyc;
      if (prev_hold) begin
        chk("rsp_valid_held", rsp_valid, 1'b1);
        chk("rsp_data_stable", rsp_data, prev_data);
      end
      if (rsp_valid && rsp_ready) first_v = -1;
      prev_hold = rsp_valid && !rsp_ready;
      prev_data = rsp_data;
    end
  end

  // Random back-pressure on the response channel.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_rdy) rsp_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    int a0, a1, a2, w;
    logic [1:0]   op;
    logic [7:0]   ad;
    logic [127:0] d;
    for (int i = 0; i < 256; i++) begin
      mem[i] = '0;
      ref_info[i] = '0;
    end
    reset = 1'b1; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_addr = 8'd0;
    cmd_data = '0; rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_vp_reset", vp_reset, 1'b1);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_vp_enable", vp_enable, 1'b0);
    chk("rst_rsp_data", rsp_data, 128'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("idle_cmd_ready", cmd_ready, 1'b1);
    chk("idle_vp_reset", vp_reset, 1'b0);

    send(2'd0, 8'h05, 128'h1A3C, 1'b0, a0);
    send(2'd0, 8'h06, 128'h0777, 1'b0, a1);
    chk("ins_ready_gap", a1 - a0, 2);

    send(2'd1, 8'h10, {32'h4, 32'h3, 32'h2, 32'h1}, 1'b0, a0);
    send(2'd3, 8'h10, 128'd0, 1'b0, a0);
    send(2'd2, 8'h00, 128'd5, 1'b0, a0);
    send(2'd2, 8'h00, 128'd0, 1'b0, a0);
    wait_drain();

    // Readback held off for four cycles.
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    send(2'd3, 8'h10, 128'd0, 1'b0, a0);
    w = 0;
    while (!rsp_valid && w < 20) begin
      @(negedge clk);
      w++;
    end
    for (int i = 0; i < 4; i++) begin
      chk("stall_rsp_valid", rsp_valid, 1'b1);
      chk("stall_cmd_ready", cmd_ready, 1'b0);
      chk("stall_busy", busy, 1'b1);
      if (i < 3) @(negedge clk);
    end
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    wait_drain();

    send(2'd0, 8'h21, 128'h1111, 1'b1, a0);
    send(2'd0, 8'h22, 128'h2222, 1'b1, a1);
    send(2'd0, 8'h23, 128'h3333, 1'b0, a2);
    chk("b2b_gap_1", a1 - a0, 2);
    chk("b2b_gap_2", a2 - a1, 2);
    wait_drain();

    // Abort a long run partway through.
    send(2'd2, 8'h00, 128'd100, 1'b0, a0);
    w = 0;
    while (en_cnt < 40 && w < 300) begin
      @(negedge clk);
      w++;
    end
    chk("abort_reached_40", en_cnt >= 40, 1'b1);
    @(posedge clk);
    #1 reset = 1'b1;
    sb.delete();
    @(negedge clk);
    chk("abort_cmd_ready_in_reset", cmd_ready, 1'b0);
    @(negedge clk);
    chk("abort_enable_off", vp_enable, 1'b0);
    chk("abort_busy_off", busy, 1'b0);
    chk("abort_done_off", done, 1'b0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("abort_cmd_ready_after", cmd_ready, 1'b1);
    repeat (110) @(negedge clk);

    rand_rdy = 1'b1;
    for (int i = 0; i < 60; i++) begin
      op = 2'($urandom_range(0, 3));
      ad = 8'($urandom_range(0, 15));
      d  = {$urandom, $urandom, $urandom, $urandom};
      if (op == 2'd2) d = 128'($urandom_range(0, 12));
      send(op, ad, d, (i < 59) ? 1'($urandom_range(0, 1)) : 1'b0, a0);
    end
    rand_rdy = 1'b0;
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    wait_drain();
    repeat (3) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", tests, fails);
    $finish;
  end

endmodule
